// File: rtl/decode_cycle_pkg.sv
// -----------------------------------------------------------------------------
// decode_cycle_pkg
//   Shared decode definitions for the RV32I decode stage:
//     - opcode constants
//     - ALUControl codes
//     - ResultSrc codes
//     - ImmSrc codes
//     - control bundle and decode/execute register layout
//   No ports; imported by decode_cycle and register_file.
// -----------------------------------------------------------------------------
package decode_cycle_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // Major opcodes (InstrD[6:0]).
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    // IMM_NONE covers R-type and undecoded opcodes: immediate is zero.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        alu_src_a;
        result_src_e result_src;
        alu_ctl_e    alu_ctl;
    } ctrl_t;

    // Decode/execute pipeline register contents.
    typedef struct packed {
        ctrl_t             ctrl;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
    } de_t;

endpackage

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32 x 32 RV32I integer register file, x0 hard-wired to zero.
//   Ports:
//     clk, rst_n          rising-edge clock, async active-low clear
//     we, waddr, wdata    write port (writes to x0 discarded)
//     raddr1/2, rdata1/2  combinational read ports with write-through bypass
// -----------------------------------------------------------------------------
module register_file
    import decode_cycle_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [REG_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [REG_W-1:0] raddr1,
    input  logic [REG_W-1:0] raddr2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    logic wr_en;
    assign wr_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    // NOTE: the array is cleared by the async reset because the block must
    // come out of reset with every register reading zero, not X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass makes a same-cycle writeback visible to the decode read.
    function automatic logic [XLEN-1:0] read_port(input logic [REG_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (wr_en && (waddr == addr)) begin
            return wdata;
        end else begin
            return regs_q[addr];
        end
    endfunction

    assign rdata1 = read_port(raddr1);
    assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle
//   RV32I decode stage: control decode, immediate extension, register file
//   read (register file owned here, written from writeback) and the
//   decode/execute pipeline register.
//   Ports:
//     clk, rst                    clock, async active-low reset
//     InstrD, PCD, PCPlus4D       from fetch/decode register
//     RegWriteW, RDW, ResultW     writeback port into the register file
//     FlushE                      load a bubble into the D/E register
//     Rs1D, Rs2D                  combinational source indices (hazard unit)
//     *E                          registered decode results for execute
// -----------------------------------------------------------------------------
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        ALUSrcAE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd;

    assign opcode    = InstrD[6:0];
    assign rd        = InstrD[11:7];
    assign funct3    = InstrD[14:12];
    assign Rs1D      = InstrD[19:15];
    assign Rs2D      = InstrD[24:20];
    assign funct7_b5 = InstrD[30];

    // ---------------------------------------------------------------- regfile
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;

    register_file u_register_file (
        .clk    (clk),
        .rst_n  (rst),
        .we     (RegWriteW),
        .waddr  (RDW),
        .wdata  (ResultW),
        .raddr1 (Rs1D),
        .raddr2 (Rs2D),
        .rdata1 (rd1_d),
        .rdata2 (rd2_d)
    );

    // ------------------------------------------------------- ALU op selection
    // Shared by R and I-ALU; only R-type can request SUB via funct7[5].
    alu_ctl_e alu_arith;

    always_comb begin
        unique case (funct3)
            3'b000:  alu_arith = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_arith = ALU_SLL;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b100:  alu_arith = ALU_XOR;
            3'b101:  alu_arith = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    end

    // -------------------------------------------------------- control decode
    ctrl_t    ctrl;
    imm_src_e imm_src;

    // NOTE: every output of this block gets a default before the case, so an
    // unlisted opcode yields a bubble and no latch can be inferred.
    always_comb begin
        ctrl    = '0;
        imm_src = IMM_NONE;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctl   = alu_arith;
            end
            OP_I_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctl   = alu_arith;
                imm_src        = IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                imm_src         = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_ctl = ALU_SUB;
                imm_src      = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_I;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------- immediate extender
    logic [31:0] imm_ext;

    always_comb begin
        unique case (imm_src)
            IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
            IMM_U:   imm_ext = {InstrD[31:12], 12'b0};
            IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // ------------------------------------------------------ D/E pipeline reg
    de_t de_d;
    de_t de_q;

    always_comb begin
        if (FlushE) begin
            de_d = '0;
        end else begin
            de_d.ctrl     = ctrl;
            de_d.funct3   = funct3;
            de_d.rd1      = rd1_d;
            de_d.rd2      = rd2_d;
            de_d.imm      = imm_ext;
            de_d.pc       = PCD;
            de_d.pc_plus4 = PCPlus4D;
            de_d.rd       = rd;
            de_d.rs1      = Rs1D;
            de_d.rs2      = Rs2D;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign RegWriteE   = de_q.ctrl.reg_write;
    assign MemWriteE   = de_q.ctrl.mem_write;
    assign JumpE       = de_q.ctrl.jump;
    assign BranchE     = de_q.ctrl.branch;
    assign ALUSrcE     = de_q.ctrl.alu_src;
    assign ALUSrcAE    = de_q.ctrl.alu_src_a;
    assign ResultSrcE  = de_q.ctrl.result_src;
    assign ALUControlE = de_q.ctrl.alu_ctl;
    assign Funct3E     = de_q.funct3;
    assign RD1E        = de_q.rd1;
    assign RD2E        = de_q.rd2;
    assign ImmExtE     = de_q.imm;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc_plus4;
    assign RdE         = de_q.rd;
    assign Rs1E        = de_q.rs1;
    assign Rs2E        = de_q.rs2;

endmodule
